apb_i2c_fifo: RTL and testbench

//  Synchronous first-word-fall-through (FWFT) FIFO that sits between the APB bridge and the I2C core.

---
 rtl/apb_i2c_pkg.sv | 15 +
 rtl/apb_i2c_fifo_if.sv | 33 +++
 rtl/apb_i2c_fifo_ram.sv | 23 ++
 rtl/apb_i2c_fifo.sv | 83 ++++++++
 tb/tb_apb_i2c_fifo.sv | 195 +++++++++++++++++++
 5 files changed

// File: rtl/apb_i2c_pkg.sv
// Shared constants and types for the APB-to-I2C bridge: FIFO geometry and APB register map.
package apb_i2c_pkg;

   localparam int FIFO_DWIDTH   = 32;
   localparam int FIFO_AWIDTH   = 4;
   localparam int FIFO_AF_LEVEL = 12;

   typedef logic [FIFO_AWIDTH:0] fifo_ptr_t;

   localparam logic [7:0] APB_ADDR_TX      = 8'h00;
   localparam logic [7:0] APB_ADDR_RX      = 8'h04;
   localparam logic [7:0] APB_ADDR_CONFIG  = 8'h08;
   localparam logic [7:0] APB_ADDR_TIMEOUT = 8'h0C;

endpackage

// File: rtl/apb_i2c_fifo_if.sv
// FIFO access bundle: the producer/consumer side (master) drives push/pop/flush, the FIFO (slave) returns data and status.
interface apb_i2c_fifo_if
   import apb_i2c_pkg::*;
#(
   parameter int DWIDTH = FIFO_DWIDTH,
   parameter int AWIDTH = FIFO_AWIDTH
) ();

   logic              WR_ENA;
   logic [DWIDTH-1:0] WRITE_DATA;
   logic              RD_ENA;
   logic [DWIDTH-1:0] READ_DATA;
   logic              FLUSH;
   logic              CLR_ERR;
   logic              EMPTY;
   logic              FULL;
   logic              ALMOST_FULL;
   logic [AWIDTH:0]   LEVEL;
   logic              OVERFLOW;
   logic              UNDERFLOW;
   logic              ERROR;

   modport master (
      output WR_ENA, WRITE_DATA, RD_ENA, FLUSH, CLR_ERR,
      input  READ_DATA, EMPTY, FULL, ALMOST_FULL, LEVEL, OVERFLOW, UNDERFLOW, ERROR
   );

   modport slave (
      input  WR_ENA, WRITE_DATA, RD_ENA, FLUSH, CLR_ERR,
      output READ_DATA, EMPTY, FULL, ALMOST_FULL, LEVEL, OVERFLOW, UNDERFLOW, ERROR
   );

endinterface

// File: rtl/apb_i2c_fifo_ram.sv
// Simple dual-port storage: synchronous write, asynchronous read so the FIFO head is visible with zero latency.
module apb_i2c_fifo_ram #(
   parameter int DWIDTH = 32,
   parameter int AWIDTH = 4
) (
   input  logic              clk,
   input  logic              we,
   input  logic [AWIDTH-1:0] waddr,
   input  logic [DWIDTH-1:0] wdata,
   input  logic [AWIDTH-1:0] raddr,
   output logic [DWIDTH-1:0] rdata
);

   logic [DWIDTH-1:0] mem [2**AWIDTH];

   // Contents are deliberately not reset; READ_DATA is masked while the FIFO is empty.
   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
   end

   assign rdata = mem[raddr];

endmodule

// File: rtl/apb_i2c_fifo.sv
// FWFT FIFO between APB bridge and I2C core; head word valid combinationally, push visible one edge later.
// A push into a full FIFO without a pop, or a pop from an empty FIFO, is dropped and latches a sticky error.
module apb_i2c_fifo
   import apb_i2c_pkg::*;
#(
   parameter int DWIDTH   = FIFO_DWIDTH,
   parameter int AWIDTH   = FIFO_AWIDTH,
   parameter int AF_LEVEL = FIFO_AF_LEVEL
) (
   input  logic          PCLK,
   input  logic          PRESETn,
   apb_i2c_fifo_if.slave bus
);

   typedef logic [AWIDTH:0] ptr_t;
   localparam ptr_t AF_THRESH = ptr_t'(AF_LEVEL);

   ptr_t              wr_ptr;
   ptr_t              rd_ptr;
   ptr_t              level;
   logic              empty;
   logic              full;
   logic              push;
   logic              pop;
   logic              push_rej;
   logic              pop_rej;
   logic              overflow;
   logic              underflow;
   logic [DWIDTH-1:0] ram_data;

   assign empty = (wr_ptr == rd_ptr);
   assign full  = (wr_ptr[AWIDTH] != rd_ptr[AWIDTH]) &&
                  (wr_ptr[AWIDTH-1:0] == rd_ptr[AWIDTH-1:0]);
   assign level = wr_ptr - rd_ptr;

   // FLUSH masks both the transfers and the error detection for its cycle.
   assign push     = bus.WR_ENA && (!full || bus.RD_ENA) && !bus.FLUSH;
   assign pop      = bus.RD_ENA && !empty && !bus.FLUSH;
   assign push_rej = bus.WR_ENA && full && !bus.RD_ENA && !bus.FLUSH;
   assign pop_rej  = bus.RD_ENA && empty && !bus.FLUSH;

   always_ff @(posedge PCLK or negedge PRESETn) begin
      if (!PRESETn) begin
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         overflow  <= 1'b0;
         underflow <= 1'b0;
      end else begin
         if (bus.FLUSH) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
         end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
         end
         // A new error in the same cycle as CLR_ERR wins.
         overflow  <= (overflow  && !bus.CLR_ERR) || push_rej;
         underflow <= (underflow && !bus.CLR_ERR) || pop_rej;
      end
   end

   apb_i2c_fifo_ram #(
      .DWIDTH (DWIDTH),
      .AWIDTH (AWIDTH)
   ) u_ram (
      .clk   (PCLK),
      .we    (push),
      .waddr (wr_ptr[AWIDTH-1:0]),
      .wdata (bus.WRITE_DATA),
      .raddr (rd_ptr[AWIDTH-1:0]),
      .rdata (ram_data)
   );

   assign bus.READ_DATA   = empty ? '0 : ram_data;
   assign bus.EMPTY       = empty;
   assign bus.FULL        = full;
   assign bus.ALMOST_FULL = (level >= AF_THRESH);
   assign bus.LEVEL       = level;
   assign bus.OVERFLOW    = overflow;
   assign bus.UNDERFLOW   = underflow;
   assign bus.ERROR       = overflow || underflow;

endmodule

// File: tb/tb_apb_i2c_fifo.sv
// Randomised and directed stimulus for apb_i2c_fifo, checked against a queue-based reference model.
module tb_apb_i2c_fifo;
   import apb_i2c_pkg::*;

   localparam int DEPTH = 2**FIFO_AWIDTH;

   logic PCLK;
   logic PRESETn;

   apb_i2c_fifo_if #(.DWIDTH(FIFO_DWIDTH), .AWIDTH(FIFO_AWIDTH)) bus ();

   apb_i2c_fifo dut (
      .PCLK    (PCLK),
      .PRESETn (PRESETn),
      .bus     (bus)
   );

   initial PCLK = 1'b0;
   always #5 PCLK = ~PCLK;

   // Reference model
   logic [31:0] q [$];
   logic        m_ovf;
   logic        m_unf;

   int n_tests;
   int n_fail;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] m_head();
      return (q.size() == 0) ? 32'h0 : q[0];
   endfunction

   task automatic check_all(input string pfx);
      int n;
      n = q.size();
      chk({pfx, "/level"}, 32'(bus.LEVEL),       32'(n));
      chk({pfx, "/empty"}, 32'(bus.EMPTY),       32'(n == 0));
      chk({pfx, "/full"},  32'(bus.FULL),        32'(n == DEPTH));
      chk({pfx, "/afull"}, 32'(bus.ALMOST_FULL), 32'(n >= FIFO_AF_LEVEL));
      chk({pfx, "/rdata"}, bus.READ_DATA,        m_head());
      chk({pfx, "/ovf"},   32'(bus.OVERFLOW),    32'(m_ovf));
      chk({pfx, "/unf"},   32'(bus.UNDERFLOW),   32'(m_unf));
      chk({pfx, "/err"},   32'(bus.ERROR),       32'(m_ovf || m_unf));
   endtask

   function automatic void model_edge(input logic wr, input logic [31:0] d, input logic rd,
                                      input logic fl, input logic clr);
      int  n;
      logic new_ovf;
      logic new_unf;
      n       = q.size();
      new_ovf = !fl && wr && !rd && (n == DEPTH);
      new_unf = !fl && rd && (n == 0);
      if (fl) begin
         q.delete();
      end else begin
         if (rd && n > 0) void'(q.pop_front());
         if (wr && (n < DEPTH || rd)) q.push_back(d);
      end
      m_ovf = (m_ovf && !clr) || new_ovf;
      m_unf = (m_unf && !clr) || new_unf;
   endfunction

   task automatic idle_inputs();
      bus.WR_ENA     = 1'b0;
      bus.WRITE_DATA = 32'h0;
      bus.RD_ENA     = 1'b0;
      bus.FLUSH      = 1'b0;
      bus.CLR_ERR    = 1'b0;
   endtask

   // Called 1 time unit after a rising edge; drives one cycle and checks after the next edge.
   task automatic step(input string pfx, input logic wr, input logic [31:0] d, input logic rd,
                       input logic fl, input logic clr);
      bus.WR_ENA     = wr;
      bus.WRITE_DATA = d;
      bus.RD_ENA     = rd;
      bus.FLUSH      = fl;
      bus.CLR_ERR    = clr;
      #1;
      if (rd) chk({pfx, "/fwft"}, bus.READ_DATA, m_head());
      @(posedge PCLK);
      model_edge(wr, d, rd, fl, clr);
      #1;
      idle_inputs();
      check_all(pfx);
   endtask

   task automatic push(input string pfx, input logic [31:0] d);
      step(pfx, 1'b1, d, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic pop(input string pfx);
      step(pfx, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] d;
      int          mode;
      n_tests = 0;
      n_fail  = 0;
      m_ovf   = 1'b0;
      m_unf   = 1'b0;
      idle_inputs();
      PRESETn = 1'b0;
      #12;
      check_all("reset");
      PRESETn = 1'b1;
      @(posedge PCLK);
      #1;

      // 1: fill, ALMOST_FULL/FULL thresholds, drain in order
      for (int i = 0; i < DEPTH; i++) push("fill", 32'h1000 + 32'(i));
      chk("fill/level16", 32'(bus.LEVEL), 32'd16);
      for (int i = 0; i < DEPTH; i++) pop("drain");
      chk("drain/empty", 32'(bus.EMPTY), 32'd1);

      // 2: overflow while full
      for (int i = 0; i < DEPTH; i++) push("fill2", 32'h2000 + 32'(i));
      push("ovf", 32'hDEAD_BEEF);
      chk("ovf/head", bus.READ_DATA, 32'h2000);
      step("clr_ovf", 1'b0, 32'h0, 1'b0, 1'b0, 1'b1);

      // 4: simultaneous push/pop while full
      step("full_pp", 1'b1, 32'h3333_0000, 1'b1, 1'b0, 1'b0);
      chk("full_pp/head", bus.READ_DATA, 32'h2001);
      for (int i = 0; i < DEPTH; i++) pop("full_pp_drain");

      // 3: underflow cases
      pop("unf_pop");
      step("clr_unf", 1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
      step("unf_pp", 1'b1, 32'h4444_4444, 1'b1, 1'b0, 1'b0);
      step("clr_unf2", 1'b0, 32'h0, 1'b1, 1'b1, 1'b1);

      // 5: random traffic across pointer wrap
      for (int i = 0; i < 40; i++) begin
         mode = $urandom_range(0, 3);
         d    = $urandom;
         case (mode)
            0: push("rnd_push", d);
            1: pop("rnd_pop");
            2: step("rnd_pp", 1'b1, d, 1'b1, 1'b0, 1'b0);
            default: begin
               push("rnd_pair_w", d);
               pop("rnd_pair_r");
            end
         endcase
      end

      // 6: flush with a concurrent push; sticky flag must survive
      step("pre_flush", 1'b0, 32'h0, 1'b0, 1'b1, 1'b1);
      pop("set_unf");
      for (int i = 0; i < 7; i++) push("lvl7", $urandom);
      chk("lvl7/level", 32'(bus.LEVEL), 32'd7);
      step("flush_wr", 1'b1, 32'h5555_5555, 1'b0, 1'b1, 1'b0);
      chk("flush_wr/unf_kept", 32'(bus.UNDERFLOW), 32'd1);

      // Asynchronous reset in the middle of a burst
      for (int i = 0; i < 5; i++) push("burst", 32'h6000 + 32'(i));
      bus.WR_ENA     = 1'b1;
      bus.WRITE_DATA = 32'h6666_6666;
      PRESETn        = 1'b0;
      #2;
      q.delete();
      m_ovf = 1'b0;
      m_unf = 1'b0;
      check_all("rst_mid");
      idle_inputs();
      #1;
      PRESETn = 1'b1;
      @(posedge PCLK);
      #1;
      check_all("post_rst");
      push("post_rst_push", 32'h7777_0001);
      chk("post_rst_push/head", bus.READ_DATA, 32'h7777_0001);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
